mcp3008_responder: RTL and testbench
====================================

# mcp3008_responder

Synthesizable SPI responder that emulates the MCP3008 ADC, the device-side end of the link driven by the team's `mcp3008`/`mcp3008_audio` initiators. It decodes start/config bits from DIN, samples one of `CHANNELS` parallel input words (single-ended or pseudo-differential), and shifts the 10-bit result out MSB-first on DOUT. It is used for hardware loopback of the audio/pot ADC path with a known digital stimulus, and as a bench model in place of the physical chip.

## Interface
- `N`, 10: result width in bits.
- `CHANNELS`, 8: number of emulated analog inputs (≤ 8).

- `clk`  input  1  system clock; must be ≥ 8× SCLK frequency.
- `reset`  input  1  synchronous, active-high reset.
- `SCLK`  input  1  SPI clock from initiator (asynchronous to `clk`).
- `CS_n`  input  1  chip select, active low (asynchronous).
- `DIN`  input  1  SPI data from initiator (asynchronous).
- `ch_data`  input  [CHANNELS-1:0][N-1:0]  emulated channel voltages, unsigned codes.
- `DOUT`  output  1  SPI data to initiator.
- `dout_oe`  output  1  DOUT drive enable (high only while `CS_n` is low and the frame is active).
- `ch_sel`  output  3  channel field D2..D0 of the last decoded frame.
- `sgl_diff`  output  1  SGL/DIFF bit of the last decoded frame.
- `conv_done`  output  1  one-`clk` pulse when the last result bit (B0) has been driven.

## Operation
- `SCLK` and `CS_n` pass through two-flop synchronizers, then edge detectors. `DIN` is synchronized only. All decisions use detected edges.
- States: IDLE, WAIT_START, CONFIG, SAMPLE, DATA, TRAIL.
- IDLE: `dout_oe`=0, `DOUT`=0. Synchronized `CS_n` low moves to WAIT_START.
- WAIT_START: on each SCLK rise, if DIN=1 go to CONFIG; DIN=0 is a leading zero and is ignored.
- CONFIG: shift 4 bits on SCLK rises (SGL/DIFF, D2, D1, D0); after the 4th, latch `sgl_diff`/`ch_sel` and go to SAMPLE.
- SAMPLE: on the next SCLK fall, latch the result, assert `dout_oe`, drive the null bit `DOUT`=0, and go to DATA.
- Result: single-ended gives `ch_data[ch_sel]`. Differential uses IN+ = `ch_data[ch_sel]` and IN− = `ch_data[ch_sel^1]`, computed N+1 bits wide; a negative result clamps to 0. Any index ≥ `CHANNELS` reads as 0.
- DATA: on each SCLK fall, drive the next bit B(N-1)..B0. The fall that drives B0 pulses `conv_done` and moves to TRAIL.
- TRAIL: `DOUT`=0 for any further SCLK falls while `CS_n` stays low.
- `CS_n` rise in any state: go to IDLE next cycle, `dout_oe`=0, `DOUT`=0, no `conv_done`. `ch_sel`/`sgl_diff` retain their values.
- `ch_data` is read only at the SAMPLE latch point. Later changes do not affect the frame in flight.

## Timing
- Reset values: `DOUT`=0, `dout_oe`=0, `ch_sel`=0, `sgl_diff`=0, `conv_done`=0, state IDLE, bit counter 0.
- Reset mid-frame aborts immediately. After reset deasserts, the block waits in IDLE until it sees a `CS_n` fall, so an in-progress frame is never resumed.
- Pin-to-action latency is 3 `clk` (2 sync + 1 edge register). `DOUT` updates 3–4 `clk` after the SCLK fall, which is well before the next SCLK rise given the ≥8× ratio.
- A `CS_n` rise and an SCLK edge detected in the same cycle: `CS_n` wins.
- Frame length is 1 start + 4 config + 1 null + N data SCLK periods (16 with leading alignment zeros, matching a 24-bit initiator transfer).

## Structure
- `mcp3008_pkg` holds: `state_t` enum, `CFG_BITS`=4, `CH_W`=3.
- Sub-module `sync_edge` (2-flop synchronizer plus rise/fall pulses) is instantiated for `SCLK` and `CS_n`. `DIN` uses its synchronized output only.

## Test plan
- Single-ended ch0, `ch_data[0]`=10'h2A5, frame 1,1,000: `DOUT` after config = 0 then 1010100101, one `conv_done` pulse, `ch_sel`=0, `sgl_diff`=1.
- Differential ch_sel=001, ch0=100, ch1=350: result 250 (0011111010). Swap values to ch0=350, ch1=100: result 0 (clamp).
- Seven leading zeros before the start bit, ch5=10'h3FF: result 1111111111 is still framed correctly. 8 extra SCLKs afterwards: `DOUT`=0 throughout, no second `conv_done`.
- `CS_n` raised after B6: within 3 `clk`, `dout_oe`=0 and state IDLE, no `conv_done`. The next full frame returns the correct value.
- `reset` pulsed during DATA with `CS_n` still low: outputs go to reset values. Further SCLKs produce nothing until `CS_n` toggles high→low; the following frame is correct.
- `CHANNELS`=2, ch_sel=011 single-ended: result 0. `ch_data` changed mid-DATA: output bits keep the latched value.

Source files
------------

// File: rtl/mcp3008_pkg.sv
// Shared types and constants for the MCP3008 responder.
//   state_t  : frame FSM states
//   CFG_BITS : config bits after the start bit (SGL/DIFF, D2, D1, D0)
//   CH_W     : channel select width
package mcp3008_pkg;

  localparam int unsigned CFG_BITS = 4;
  localparam int unsigned CH_W     = 3;

  typedef enum logic [2:0] {
    StIdle,
    StWaitStart,
    StConfig,
    StSample,
    StData,
    StTrail
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by an edge register.
// Ports:
//   i_clk, i_reset : system clock, synchronous active-high reset
//   i_async        : asynchronous input
//   o_sync         : synchronized level
//   o_rise, o_fall : single-cycle pulses on synchronized edges
module sync_edge (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // All flops reset low. For CS_n this means a select held low across reset
  // yields no rise, so the responder stays disarmed until CS_n goes high.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/mcp3008_responder.sv
// SPI responder emulating an MCP3008 ADC.
// Ports:
//   clk, reset : system clock (>= 8x SCLK), synchronous active-high reset
//   SCLK, CS_n, DIN : SPI from initiator (asynchronous to clk)
//   ch_data    : emulated channel codes, sampled when the result is latched
//   DOUT, dout_oe : SPI data to initiator and its drive enable
//   ch_sel, sgl_diff : config fields of the last decoded frame
//   conv_done  : one-clk pulse when B0 has been driven
module mcp3008_responder
  import mcp3008_pkg::*;
#(
  parameter int unsigned N        = 10,
  parameter int unsigned CHANNELS = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         SCLK,
  input  logic                         CS_n,
  input  logic                         DIN,
  input  logic [CHANNELS-1:0][N-1:0]   ch_data,
  output logic                         DOUT,
  output logic                         dout_oe,
  output logic [CH_W-1:0]              ch_sel,
  output logic                         sgl_diff,
  output logic                         conv_done
);

  localparam int unsigned MaxCh = 2 ** CH_W;
  localparam int unsigned CntW  = $clog2((N > CFG_BITS) ? N : CFG_BITS);

  logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
  logic w_cs_sync, w_cs_rise, w_cs_fall;
  logic w_unused;

  sync_edge u_sclk_sync (
    .i_clk   (clk),
    .i_reset (reset),
    .i_async (SCLK),
    .o_sync  (w_sclk_sync),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  sync_edge u_cs_sync (
    .i_clk   (clk),
    .i_reset (reset),
    .i_async (CS_n),
    .o_sync  (w_cs_sync),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  assign w_unused = w_sclk_sync ^ w_cs_fall;

  // DIN shares the SCLK synchronizer depth, so it lines up with the rise pulse.
  logic r_din_meta, r_din_sync;

  state_t              r_state, w_state_nxt;
  logic [CntW-1:0]     r_cnt, w_cnt_nxt;
  logic [CFG_BITS-1:0] r_cfg, w_cfg_nxt;
  logic [N-1:0]        r_shift, w_shift_nxt;
  logic                r_dout, w_dout_nxt;
  logic                r_oe, w_oe_nxt;
  logic                r_done, w_done_nxt;
  logic [CH_W-1:0]     r_ch_sel, w_ch_sel_nxt;
  logic                r_sgl_diff, w_sgl_diff_nxt;
  // Set by a CS_n rise; a frame may only start from IDLE once armed, so a
  // frame interrupted by reset is never resumed.
  logic                r_armed, w_armed_nxt;

  // Channel table padded to the full select range; absent channels read 0.
  logic [N-1:0] w_ch [MaxCh];
  for (genvar g = 0; g < MaxCh; g++) begin : g_ch
    if (g < CHANNELS) begin : g_live
      assign w_ch[g] = ch_data[g];
    end else begin : g_absent
      assign w_ch[g] = '0;
    end
  end

  logic [N-1:0] w_pos, w_neg, w_result;
  logic [N:0]   w_diff;

  assign w_pos  = w_ch[r_ch_sel];
  assign w_neg  = w_ch[r_ch_sel ^ CH_W'(1)];
  assign w_diff = {1'b0, w_pos} - {1'b0, w_neg};

  always_comb begin
    if (r_sgl_diff) begin
      w_result = w_pos;
    end else if (w_diff[N]) begin
      w_result = '0;  // IN- above IN+ clamps to zero
    end else begin
      w_result = w_diff[N-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_din_meta <= 1'b0;
      r_din_sync <= 1'b0;
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_cfg      <= '0;
      r_shift    <= '0;
      r_dout     <= 1'b0;
      r_oe       <= 1'b0;
      r_done     <= 1'b0;
      r_ch_sel   <= '0;
      r_sgl_diff <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_din_meta <= DIN;
      r_din_sync <= r_din_meta;
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_cfg      <= w_cfg_nxt;
      r_shift    <= w_shift_nxt;
      r_dout     <= w_dout_nxt;
      r_oe       <= w_oe_nxt;
      r_done     <= w_done_nxt;
      r_ch_sel   <= w_ch_sel_nxt;
      r_sgl_diff <= w_sgl_diff_nxt;
      r_armed    <= w_armed_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_cfg_nxt      = r_cfg;
    w_shift_nxt    = r_shift;
    w_dout_nxt     = r_dout;
    w_oe_nxt       = r_oe;
    w_done_nxt     = 1'b0;
    w_ch_sel_nxt   = r_ch_sel;
    w_sgl_diff_nxt = r_sgl_diff;
    w_armed_nxt    = r_armed | w_cs_rise;

    if (w_cs_rise) begin
      // Deselect overrides any SCLK edge seen in the same cycle.
      w_state_nxt = StIdle;
      w_cnt_nxt   = '0;
      w_dout_nxt  = 1'b0;
      w_oe_nxt    = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_dout_nxt = 1'b0;
          w_oe_nxt   = 1'b0;
          if (r_armed && !w_cs_sync) begin
            w_state_nxt = StWaitStart;
            w_armed_nxt = 1'b0;
            w_cnt_nxt   = '0;
          end
        end
        StWaitStart: begin
          if (w_sclk_rise && r_din_sync) begin
            w_state_nxt = StConfig;
            w_cnt_nxt   = '0;
          end
        end
        StConfig: begin
          if (w_sclk_rise) begin
            w_cfg_nxt = {r_cfg[CFG_BITS-2:0], r_din_sync};
            if (r_cnt == CntW'(CFG_BITS - 1)) begin
              w_sgl_diff_nxt = w_cfg_nxt[CFG_BITS-1];
              w_ch_sel_nxt   = w_cfg_nxt[CH_W-1:0];
              w_state_nxt    = StSample;
              w_cnt_nxt      = '0;
            end else begin
              w_cnt_nxt = r_cnt + CntW'(1);
            end
          end
        end
        StSample: begin
          if (w_sclk_fall) begin
            w_shift_nxt = w_result;
            w_oe_nxt    = 1'b1;
            w_dout_nxt  = 1'b0;  // null bit
            w_state_nxt = StData;
            w_cnt_nxt   = '0;
          end
        end
        StData: begin
          if (w_sclk_fall) begin
            w_dout_nxt  = r_shift[N-1];
            w_shift_nxt = {r_shift[N-2:0], 1'b0};
            if (r_cnt == CntW'(N - 1)) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = StTrail;
            end else begin
              w_cnt_nxt = r_cnt + CntW'(1);
            end
          end
        end
        StTrail: begin
          if (w_sclk_fall) begin
            w_dout_nxt = 1'b0;
          end
        end
        default: begin
          w_state_nxt = StIdle;
        end
      endcase
    end
  end

  assign DOUT      = r_dout;
  assign dout_oe   = r_oe;
  assign ch_sel    = r_ch_sel;
  assign sgl_diff  = r_sgl_diff;
  assign conv_done = r_done;

endmodule

// File: tb/tb_mcp3008_responder.sv
module tb_mcp3008_responder;

  localparam int N    = 10;
  localparam int HALF = 8;  // clk cycles per SCLK half period

  logic clk = 1'b0;
  logic reset, SCLK, CS_n, DIN;
  logic [7:0][N-1:0] ch_data;
  logic [1:0][N-1:0] ch_data2;
  logic dout, oe, cd, sd;
  logic [2:0] sel;
  logic dout2, oe2, cd2, sd2;
  logic [2:0] sel2;

  assign ch_data2 = ch_data[1:0];

  mcp3008_responder #(.N(N), .CHANNELS(8)) dut (
    .clk(clk), .reset(reset), .SCLK(SCLK), .CS_n(CS_n), .DIN(DIN),
    .ch_data(ch_data), .DOUT(dout), .dout_oe(oe), .ch_sel(sel),
    .sgl_diff(sd), .conv_done(cd)
  );

  mcp3008_responder #(.N(N), .CHANNELS(2)) dut2 (
    .clk(clk), .reset(reset), .SCLK(SCLK), .CS_n(CS_n), .DIN(DIN),
    .ch_data(ch_data2), .DOUT(dout2), .dout_oe(oe2), .ch_sel(sel2),
    .sgl_diff(sd2), .conv_done(cd2)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int n_done = 0, n_done2 = 0;

  always @(negedge clk) begin
    if (cd)  n_done++;
    if (cd2) n_done2++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [N:0] cap, cap2;  // {null bit, B(N-1)..B0}
  logic trail_bad, trail_bad2, oe_mid, oe_mid2, oe_after, dout_after;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Result from the device rules, independent of any framing detail.
  function automatic int model(input bit sgl, input int ch, input int chans,
                               input logic [7:0][N-1:0] d);
    int p, m;
    p = (ch < chans) ? int'(d[ch]) : 0;
    if (sgl) return p;
    m = ((ch ^ 1) < chans) ? int'(d[ch ^ 1]) : 0;
    return (p > m) ? p - m : 0;
  endfunction

  // One SCLK period: drive DIN while low, sample DOUT just before the rise.
  task automatic sclk_cycle(input logic din, output logic s1, output logic s2);
    DIN = din;
    repeat (HALF) @(posedge clk);
    #1;
    s1 = dout;
    s2 = dout2;
    SCLK = 1'b1;
    repeat (HALF) @(posedge clk);
    #1 SCLK = 1'b0;
  endtask

  task automatic run_frame(input int lead, input bit sgl, input logic [2:0] ch,
                           input int extra, input int stop_after, input bit scramble);
    int   total;
    logic din, s1, s2;
    total = lead + 16 + extra;
    cap = '0; cap2 = '0;
    trail_bad = 1'b0; trail_bad2 = 1'b0;
    oe_mid = 1'b0; oe_mid2 = 1'b0;
    CS_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    for (int p = 1; p <= total; p++) begin
      if (p <= lead)           din = 1'b0;
      else if (p == lead + 1)  din = 1'b1;
      else if (p == lead + 2)  din = sgl;
      else if (p <= lead + 5)  din = ch[lead + 5 - p];
      else                     din = 1'b0;
      if (scramble && p == lead + 9) begin
        for (int i = 0; i < 8; i++) ch_data[i] = N'($urandom_range(0, 1023));
      end
      sclk_cycle(din, s1, s2);
      if (p == lead + 8) begin
        oe_mid  = oe;
        oe_mid2 = oe2;
      end
      if (p >= lead + 6 && p <= lead + 16) begin
        cap  = {cap[N-1:0], s1};
        cap2 = {cap2[N-1:0], s2};
      end else if (p > lead + 16) begin
        trail_bad  = trail_bad | s1;
        trail_bad2 = trail_bad2 | s2;
      end
      if (p == stop_after) break;
    end
    CS_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    oe_after   = oe;
    dout_after = dout;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input bit sgl, input logic [2:0] ch,
                             input logic [N-1:0] exp, input logic [N-1:0] exp2,
                             input int done0, input int done20, input bit chk_trail);
    check({tag, " null"}, 32'(cap[N]), 32'(0));
    check({tag, " data"}, 32'(cap[N-1:0]), 32'(exp));
    check({tag, " data ch2"}, 32'(cap2[N-1:0]), 32'(exp2));
    check({tag, " conv_done"}, 32'(n_done - done0), 32'(1));
    check({tag, " conv_done ch2"}, 32'(n_done2 - done20), 32'(1));
    check({tag, " ch_sel"}, 32'(sel), 32'(ch));
    check({tag, " sgl_diff"}, 32'(sd), 32'(sgl));
    check({tag, " ch_sel ch2"}, 32'(sel2), 32'(ch));
    check({tag, " sgl_diff ch2"}, 32'(sd2), 32'(sgl));
    check({tag, " oe mid"}, 32'({oe_mid, oe_mid2}), 32'(2'b11));
    check({tag, " oe after cs"}, 32'(oe_after), 32'(0));
    if (chk_trail) check({tag, " trail"}, 32'({trail_bad, trail_bad2}), 32'(0));
  endtask

  typedef struct {
    int         lead;
    bit         sgl;
    logic [2:0] ch;
    int         ia;
    logic [9:0] va;
    int         ib;
    logic [9:0] vb;
    int         extra;
    bit         scr;
    logic [9:0] exp;
    logic [9:0] exp2;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int d0, d20;
    logic din, s1, s2, oe_bad;
    bit sgl;
    logic [2:0] ch;
    int lead, e, e2;

    vecs[0] = '{0, 1'b1, 3'd0, 0, 10'h2A5, 1, 10'h000, 0, 1'b0, 10'h2A5, 10'h2A5};
    vecs[1] = '{0, 1'b0, 3'd1, 0, 10'h064, 1, 10'h15E, 0, 1'b0, 10'h0FA, 10'h0FA};
    vecs[2] = '{0, 1'b0, 3'd1, 0, 10'h15E, 1, 10'h064, 0, 1'b0, 10'h000, 10'h000};
    vecs[3] = '{7, 1'b1, 3'd5, 5, 10'h3FF, 0, 10'h000, 8, 1'b0, 10'h3FF, 10'h000};
    vecs[4] = '{1, 1'b1, 3'd3, 3, 10'h1C3, 0, 10'h000, 0, 1'b0, 10'h1C3, 10'h000};
    vecs[5] = '{2, 1'b1, 3'd2, 2, 10'h155, 0, 10'h000, 0, 1'b1, 10'h155, 10'h000};
    vecs[6] = '{3, 1'b0, 3'd0, 0, 10'h0C8, 1, 10'h032, 2, 1'b0, 10'h096, 10'h096};

    reset = 1'b1; SCLK = 1'b0; CS_n = 1'b1; DIN = 1'b0; ch_data = '0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    check("reset DOUT", 32'(dout), 32'(0));
    check("reset dout_oe", 32'(oe), 32'(0));
    check("reset ch_sel", 32'(sel), 32'(0));
    check("reset sgl_diff", 32'(sd), 32'(0));
    check("reset conv_done", 32'(cd), 32'(0));
    repeat (8) @(posedge clk);
    #1;

    // Directed table
    foreach (vecs[k]) begin
      ch_data = '0;
      ch_data[vecs[k].ia] = vecs[k].va;
      ch_data[vecs[k].ib] = vecs[k].vb;
      d0 = n_done; d20 = n_done2;
      run_frame(vecs[k].lead, vecs[k].sgl, vecs[k].ch, vecs[k].extra, -1, vecs[k].scr);
      check_frame($sformatf("vec%0d", k), vecs[k].sgl, vecs[k].ch, vecs[k].exp,
                  vecs[k].exp2, d0, d20, vecs[k].extra > 0);
    end

    // Deselect after B6: no conv_done, outputs quiet, next frame intact
    ch_data = '0;
    ch_data[6] = 10'h2C3;
    d0 = n_done;
    run_frame(2, 1'b1, 3'd6, 0, 2 + 9, 1'b0);
    check("abort dout_oe", 32'(oe_after), 32'(0));
    check("abort DOUT", 32'(dout_after), 32'(0));
    check("abort conv_done", 32'(n_done - d0), 32'(0));
    d0 = n_done; d20 = n_done2;
    run_frame(2, 1'b1, 3'd6, 0, -1, 1'b0);
    check_frame("post-abort", 1'b1, 3'd6, 10'h2C3, 10'h000, d0, d20, 1'b0);

    // Reset during DATA with CS_n held low
    ch_data = '0;
    ch_data[4] = 10'h1F0;
    d0 = n_done;
    CS_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    for (int p = 0; p < 9; p++) begin
      din = (p < 3) ? 1'b1 : 1'b0;  // start, SGL=1, D2=1, D1=D0=0, then null/B9..B7
      sclk_cycle(din, s1, s2);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("midreset DOUT", 32'(dout), 32'(0));
    check("midreset dout_oe", 32'(oe), 32'(0));
    check("midreset ch_sel", 32'(sel), 32'(0));
    check("midreset sgl_diff", 32'(sd), 32'(0));
    oe_bad = 1'b0;
    for (int p = 0; p < 20; p++) begin
      din = (p % 3 == 0) ? 1'b1 : 1'b0;
      sclk_cycle(din, s1, s2);
      oe_bad = oe_bad | oe | s1;
    end
    check("midreset no resume", 32'(oe_bad), 32'(0));
    check("midreset conv_done", 32'(n_done - d0), 32'(0));
    CS_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    d0 = n_done; d20 = n_done2;
    run_frame(0, 1'b1, 3'd4, 0, -1, 1'b0);
    check_frame("post-reset", 1'b1, 3'd4, 10'h1F0, 10'h000, d0, d20, 1'b0);

    // Randomized frames against the reference model
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < 8; i++) ch_data[i] = N'($urandom_range(0, 1023));
      sgl  = 1'($urandom_range(0, 1));
      ch   = 3'($urandom_range(0, 7));
      lead = int'($urandom_range(0, 7));
      e    = model(sgl, int'(ch), 8, ch_data);
      e2   = model(sgl, int'(ch), 2, ch_data);
      d0 = n_done; d20 = n_done2;
      run_frame(lead, sgl, ch, int'($urandom_range(0, 3)), -1, r[0]);
      check_frame($sformatf("rand%0d", r), sgl, ch, N'(e), N'(e2), d0, d20, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
